round_sequencer: RTL and testbench

//  Top-level round controller for the game console. Sequences one round as

---
 rtl/game_pkg.sv | 18 +
 rtl/sec_tick_gen.sv | 30 +++
 rtl/round_sequencer.sv | 149 ++++++++++++++
 tb/tb_round_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and banner indices for the round sequencer
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REGEN,
    ST_COUNTDOWN,
    ST_RUN,
    ST_RESULT,
    ST_ERROR
  } state_t;

  localparam int BANNER_TITLE = 0;
  localparam int BANNER_WIN   = 1;
  localparam int BANNER_LOSE  = 2;
  localparam int BANNER_ERROR = 3;

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - one-second strobe generator with clear and hold
module sec_tick_gen #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic arst_n,
  input  logic i_clear,
  input  logic i_hold,
  output logic o_tick
);

  localparam int CW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ_HZ - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (!i_hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Not gated by i_clear: the tick itself is what ends COUNTDOWN/RESULT.
  assign o_tick = (cnt == LAST) && !i_hold;

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - round controller: regen, countdown, run, result banner
module round_sequencer
  import game_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int COUNTDOWN_SEC = 3,
  parameter int RESULT_SEC    = 2,
  parameter int READY_TIMEOUT = 1_000_000,
  parameter int RATING_WIDTH  = 8,
  parameter int NUM_IMAGES    = 4
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           i_start,
  input  logic                           i_pause,
  input  logic                           i_win1,
  input  logic                           i_lose1,
  input  logic                           i_lose2,
  input  logic                           i_ready,
  output logic                           o_regenerate_level,
  output logic                           o_game_running,
  output logic                           o_show_banner,
  output logic [$clog2(NUM_IMAGES)-1:0]  o_image_number,
  output logic [RATING_WIDTH-1:0]        o_rating,
  output logic [3:0]                     o_countdown
);

  localparam int IMG_W = $clog2(NUM_IMAGES);
  localparam int TMO_W = $clog2(READY_TIMEOUT + 1);
  localparam int RES_W = $clog2(RESULT_SEC + 1);

  state_t            state;
  state_t            next_state;
  logic              start_q;
  logic              start_edge;
  logic              lose_evt;
  logic              win_evt;
  logic              tick;
  logic              tick_clear;
  logic              tick_hold;
  logic [TMO_W-1:0]  wait_cnt;
  logic [RES_W-1:0]  res_cnt;
  logic              res_win;

  assign start_edge = i_start && !start_q;
  assign lose_evt   = !i_pause && (i_lose1 || i_lose2);
  assign win_evt    = !i_pause && i_win1;
  assign tick_clear = (next_state != state);
  assign tick_hold  = (state == ST_COUNTDOWN) && i_pause;

  sec_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .clk    (clk),
    .arst_n (arst_n),
    .i_clear(tick_clear),
    .i_hold (tick_hold),
    .o_tick (tick)
  );

  // The regen pulse marks the first REGEN cycle, where i_ready is not yet trusted.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (start_edge) next_state = ST_REGEN;
      ST_REGEN: begin
        if (!o_regenerate_level && i_ready) next_state = ST_COUNTDOWN;
        else if (wait_cnt == TMO_W'(READY_TIMEOUT - 1)) next_state = ST_ERROR;
      end
      ST_COUNTDOWN: if (tick && o_countdown == 4'd1) next_state = ST_RUN;
      ST_RUN:       if (lose_evt || win_evt) next_state = ST_RESULT;
      ST_RESULT: begin
        if (tick && res_cnt == RES_W'(RESULT_SEC - 1))
          next_state = res_win ? ST_REGEN : ST_IDLE;
      end
      ST_ERROR:     if (start_edge) next_state = ST_REGEN;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state              <= ST_IDLE;
      start_q            <= 1'b0;
      wait_cnt           <= '0;
      res_cnt            <= '0;
      res_win            <= 1'b0;
      o_regenerate_level <= 1'b0;
      o_game_running     <= 1'b0;
      o_show_banner      <= 1'b1;
      o_image_number     <= IMG_W'(BANNER_TITLE);
      o_rating           <= '0;
      o_countdown        <= 4'd0;
    end else begin
      start_q            <= i_start;
      state              <= next_state;
      o_regenerate_level <= 1'b0;
      o_game_running     <= (next_state == ST_RUN) && !i_pause;

      if (next_state != state) begin
        case (next_state)
          ST_IDLE: begin
            o_show_banner  <= 1'b1;
            o_image_number <= IMG_W'(BANNER_TITLE);
          end
          ST_REGEN: begin
            o_regenerate_level <= 1'b1;
            wait_cnt           <= '0;
          end
          ST_COUNTDOWN: begin
            o_show_banner <= 1'b0;
            o_countdown   <= 4'(COUNTDOWN_SEC);
          end
          ST_RUN: begin
            o_show_banner <= 1'b0;
            o_countdown   <= 4'd0;
          end
          ST_RESULT: begin
            o_show_banner <= 1'b1;
            res_cnt       <= '0;
            // Lose wins a tie with a same-cycle win.
            if (lose_evt) begin
              res_win        <= 1'b0;
              o_image_number <= IMG_W'(BANNER_LOSE);
              if (o_rating != '0) o_rating <= o_rating - 1'b1;
            end else begin
              res_win        <= 1'b1;
              o_image_number <= IMG_W'(BANNER_WIN);
              if (o_rating != '1) o_rating <= o_rating + 1'b1;
            end
          end
          ST_ERROR: begin
            o_show_banner  <= 1'b1;
            o_image_number <= IMG_W'(BANNER_ERROR);
          end
          default: ;
        endcase
      end else begin
        case (state)
          ST_REGEN:     wait_cnt <= wait_cnt + 1'b1;
          ST_COUNTDOWN: if (tick) o_countdown <= o_countdown - 4'd1;
          ST_RESULT:    if (tick) res_cnt <= res_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - self-checking bench for round_sequencer
module tb_round_sequencer;

  localparam int CLKF = 10;
  localparam int CDS  = 3;
  localparam int RESS = 2;
  localparam int TMO  = 50;

  localparam int M_IDLE = 0, M_REGEN = 1, M_CD = 2, M_RUN = 3, M_RES = 4, M_ERR = 5;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic i_start = 1'b0, i_pause = 1'b0, i_win1 = 1'b0;
  logic i_lose1 = 1'b0, i_lose2 = 1'b0, i_ready = 1'b0;
  logic       o_regenerate_level, o_game_running, o_show_banner;
  logic [1:0] o_image_number;
  logic [7:0] o_rating;
  logic [3:0] o_countdown;

  int checks = 0;
  int errors = 0;

  round_sequencer #(
    .CLK_FREQ_HZ(CLKF), .COUNTDOWN_SEC(CDS), .RESULT_SEC(RESS),
    .READY_TIMEOUT(TMO), .RATING_WIDTH(8), .NUM_IMAGES(4)
  ) dut (
    .clk(clk), .arst_n(arst_n), .i_start(i_start), .i_pause(i_pause),
    .i_win1(i_win1), .i_lose1(i_lose1), .i_lose2(i_lose2), .i_ready(i_ready),
    .o_regenerate_level(o_regenerate_level), .o_game_running(o_game_running),
    .o_show_banner(o_show_banner), .o_image_number(o_image_number),
    .o_rating(o_rating), .o_countdown(o_countdown)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Phase/elapsed-time model: outputs follow from time spent in each phase.
  int ph = M_IDLE, el = 0, m_rating = 0, m_img = 0, m_cd = 0;
  bit st_prev = 0, won = 0, m_regen = 0, m_run = 0, m_banner = 1;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ph = M_IDLE; el = 0; m_rating = 0; m_img = 0; m_cd = 0;
      st_prev = 0; won = 0; m_regen = 0; m_run = 0; m_banner = 1;
    end else begin
      int nph;
      bit s_edge;
      nph = ph;
      s_edge = i_start && !st_prev;
      st_prev = i_start;
      case (ph)
        M_IDLE:  if (s_edge) nph = M_REGEN;
        M_REGEN: if (el >= 1 && i_ready) nph = M_CD; else if (el == TMO - 1) nph = M_ERR;
        M_CD:    if (!i_pause && el + 1 == CDS * CLKF) nph = M_RUN;
        M_RUN: begin
          if (!i_pause && (i_lose1 || i_lose2)) begin
            nph = M_RES; won = 0; if (m_rating > 0) m_rating--;
          end else if (!i_pause && i_win1) begin
            nph = M_RES; won = 1; if (m_rating < 255) m_rating++;
          end
        end
        M_RES:   if (el + 1 == RESS * CLKF) nph = won ? M_REGEN : M_IDLE;
        M_ERR:   if (s_edge) nph = M_REGEN;
        default: nph = M_IDLE;
      endcase
      if (nph != ph) el = 0;
      else if (!(ph == M_CD && i_pause)) el++;
      ph = nph;
      m_regen = (ph == M_REGEN) && (el == 0);
      m_run   = (ph == M_RUN) && !i_pause;
      case (ph)
        M_IDLE:       begin m_banner = 1; m_img = 0; end
        M_CD, M_RUN:  m_banner = 0;
        M_RES:        begin m_banner = 1; m_img = won ? 1 : 2; end
        M_ERR:        begin m_banner = 1; m_img = 3; end
        default: ;
      endcase
      m_cd = (ph == M_CD) ? CDS - el / CLKF : 0;
    end
  end

  always @(negedge clk) begin
    if (arst_n) begin
      chk("cmp_regen",   o_regenerate_level, m_regen);
      chk("cmp_running", o_game_running,     m_run);
      chk("cmp_banner",  o_show_banner,      m_banner);
      chk("cmp_image",   o_image_number,     m_img);
      chk("cmp_rating",  o_rating,           m_rating);
      chk("cmp_cd",      o_countdown,        m_cd);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_running(input int budget);
    int k = 0;
    while (o_game_running !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_running", o_game_running, 1);
  endtask

  task automatic play_win();
    i_win1 = 1; step(1); i_win1 = 0;
    wait_running(200);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_regen"},   o_regenerate_level, 0);
    chk({tag, "_running"}, o_game_running,     0);
    chk({tag, "_banner"},  o_show_banner,      1);
    chk({tag, "_image"},   o_image_number,     0);
    chk({tag, "_rating"},  o_rating,           0);
    chk({tag, "_cd"},      o_countdown,        0);
  endtask

  initial begin
    step(3);
    chk_reset_vals("reset");
    arst_n = 1; step(1);

    // 1: start, ready two cycles after the pulse, countdown 3-2-1
    i_start = 1; step(1);
    chk("t1_regen_pulse", o_regenerate_level, 1);
    i_start = 0; step(1);
    chk("t1_pulse_once", o_regenerate_level, 0);
    step(1); i_ready = 1; step(1);
    i_ready = 0;
    chk("t1_cd3", o_countdown, 3);
    chk("t1_model_cd3", m_cd, 3);
    step(10); chk("t1_cd2", o_countdown, 2);
    step(10); chk("t1_cd1", o_countdown, 1);
    step(9);  chk("t1_not_yet_running", o_game_running, 0);
    step(1);  chk("t1_running", o_game_running, 1);
    chk("t1_cd0", o_countdown, 0);
    chk("t1_model_run", ph, M_RUN);

    // 2: simultaneous win and lose -> lose, rating saturates at 0
    i_win1 = 1; i_lose2 = 1; step(1);
    i_win1 = 0; i_lose2 = 0;
    chk("t2_image_lose", o_image_number, 2);
    chk("t2_rating0", o_rating, 0);
    chk("t2_banner", o_show_banner, 1);
    step(19); chk("t2_still_result", o_image_number, 2);
    step(1);  chk("t2_idle_title", o_image_number, 0);
    chk("t2_model_idle", ph, M_IDLE);

    // 4: no ready -> error banner 50 cycles after the pulse, start recovers
    i_start = 1; step(1);
    chk("t4_regen_pulse", o_regenerate_level, 1);
    i_start = 0;
    step(49); chk("t4_no_error_yet", o_image_number, 0);
    step(1);  chk("t4_error_image", o_image_number, 3);
    chk("t4_banner", o_show_banner, 1);
    i_start = 1; step(1);
    chk("t4_restart_pulse", o_regenerate_level, 1);
    i_start = 0;

    // 5: pause 25 cycles mid-countdown delays RUN by exactly 25
    i_ready = 1;
    step(2); chk("t5_cd3", o_countdown, 3);
    step(14); chk("t5_cd2", o_countdown, 2);
    i_pause = 1;
    step(12); chk("t5_frozen_a", o_countdown, 2);
    step(13); chk("t5_frozen_b", o_countdown, 2);
    i_pause = 0;
    step(15); chk("t5_not_running", o_game_running, 0);
    chk("t5_cd1", o_countdown, 1);
    step(1); chk("t5_running", o_game_running, 1);

    // 6: five wins, then asynchronous reset mid-RUN
    repeat (5) play_win();
    chk("t6_rating5", o_rating, 5);
    chk("t6_image_win", o_image_number, 1);
    #2 arst_n = 0;
    #1 chk_reset_vals("t6_async");
    step(2); arst_n = 1; step(1);

    // 3: drive rating to 255, another win saturates and starts a new round
    i_start = 1; step(1); i_start = 0;
    wait_running(100);
    repeat (255) play_win();
    chk("t3_rating255", o_rating, 255);
    i_win1 = 1; step(1); i_win1 = 0;
    chk("t3_rating_sat", o_rating, 255);
    chk("t3_image_win", o_image_number, 1);
    step(19); chk("t3_no_regen_yet", o_regenerate_level, 0);
    step(1);  chk("t3_regen_pulse", o_regenerate_level, 1);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
